// File: rtl/sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sram_port_arbiter
// Brief   : Shares one synchronous SRAM port between IF fetches and MEM loads/stores.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_port_arbiter #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ok,
    input  logic              flush,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_I = 2'd1;
    localparam logic [1:0] S_WAIT_D = 2'd2;

    // The counter is loaded one below RD_LAT so that it reads 0 in cycle N+RD_LAT.
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic              discard;
    logic              is_store;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       wdata_hold;

    logic              issue_d;
    logic              issue_i;
    logic              done;
    logic              kill;
    logic [3:0]        store_wen;

    assign issue_d = (state == S_IDLE) && !rst && !flush && data_req;
    assign issue_i = (state == S_IDLE) && !rst && !flush && !data_req && inst_req;
    assign done    = (state != S_IDLE) && (cnt == 3'd0);
    assign kill    = discard || flush;

    always_comb begin
        store_wen = 4'b1111;
        case (data_size)
            2'd0:    store_wen = 4'b0001 << data_addr[1:0];
            2'd1:    store_wen = data_addr[1] ? 4'b1100 : 4'b0011;
            default: store_wen = 4'b1111;
        endcase
    end

    assign sram_en    = issue_d || issue_i;
    assign sram_wen   = (issue_d && data_wr) ? store_wen : 4'b0000;
    assign sram_addr  = issue_d ? data_addr : (issue_i ? inst_addr : addr_hold);
    assign sram_wdata = sram_en ? data_wdata : wdata_hold;

    // A store has already hit the memory, so a flush cannot hide its completion.
    assign inst_ok    = done && (state == S_WAIT_I) && !kill;
    assign data_ok    = done && (state == S_WAIT_D) && (is_store || !kill);
    assign inst_rdata = inst_ok ? sram_rdata : 32'h0;
    assign data_rdata = data_ok ? sram_rdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            discard    <= 1'b0;
            is_store   <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sram_en) begin
                        state      <= issue_d ? S_WAIT_D : S_WAIT_I;
                        cnt        <= LAT_M1;
                        discard    <= 1'b0;
                        is_store   <= issue_d && data_wr;
                        addr_hold  <= sram_addr;
                        wdata_hold <= data_wdata;
                    end
                end
                S_WAIT_I, S_WAIT_D: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (cnt == 3'd0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_sram_port_arbiter
// Brief   : Scenario bench for sram_port_arbiter at RD_LAT = 1, 2 and 3.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sram_port_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          flush;
    logic [31:0]   sram_rdata;

    logic [31:0]   inst_rdata [3];
    logic          inst_ok    [3];
    logic [31:0]   data_rdata [3];
    logic          data_ok    [3];
    logic          sram_en    [3];
    logic [3:0]    sram_wen   [3];
    logic [AW-1:0] sram_addr  [3];
    logic [31:0]   sram_wdata [3];

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   inst_q [$];
    logic [31:0]   data_q [$];

    always #5 clk = ~clk;

    // Instance g sees RD_LAT = g+1; all share the same stimulus.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            sram_port_arbiter #(.RD_LAT(g + 1), .ADDR_W(AW)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .inst_req   (inst_req),
                .inst_addr  (inst_addr),
                .inst_rdata (inst_rdata[g]),
                .inst_ok    (inst_ok[g]),
                .data_req   (data_req),
                .data_wr    (data_wr),
                .data_size  (data_size),
                .data_addr  (data_addr),
                .data_wdata (data_wdata),
                .data_rdata (data_rdata[g]),
                .data_ok    (data_ok[g]),
                .flush      (flush),
                .sram_en    (sram_en[g]),
                .sram_wen   (sram_wen[g]),
                .sram_addr  (sram_addr[g]),
                .sram_wdata (sram_wdata[g]),
                .sram_rdata (sram_rdata)
            );
        end
    endgenerate

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = '0;
        data_wdata = 32'h0;
        flush      = 1'b0;
        sram_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        logic [134:0] outs;
        idle_inputs();
        rst        = 1'b1;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        data_wdata = 32'hFFFF_FFFF;
        #1;
        for (int k = 0; k < 3; k++) begin
            outs = {sram_en[k], sram_wen[k], sram_addr[k], sram_wdata[k],
                    inst_ok[k], data_ok[k], inst_rdata[k], data_rdata[k]};
            n_cmp++;
            if (outs !== '0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got %h required 0", k, outs);
            end
        end
        cyc();
        idle_inputs();
        rst = 1'b0;
        cyc();
        // Load issued, then reset lands in the cycle its data_ok would pulse.
        data_req  = 1'b1;
        data_addr = 32'h8000_1004;
        #1;
        n_cmp++;
        if (sram_en[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_issue: sram_en got %b required 1", sram_en[0]);
        end
        cyc();
        rst      = 1'b1;
        data_req = 1'b0;
        sram_rdata = 32'h1234_5678;
        #1;
        outs = {sram_en[0], sram_wen[0], sram_addr[0], sram_wdata[0],
                inst_ok[0], data_ok[0], inst_rdata[0], data_rdata[0]};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL rst_mid_wait_outputs: got %h required 0", outs);
        end
        cyc();
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (data_ok[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_late_ok: data_ok got %b required 0", data_ok[0]);
        end
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        n_cmp++;
        if ({sram_en[0], sram_addr[0]} !== {1'b1, 32'hBFC0_0000}) begin
            n_err++;
            $display("FAIL rst_then_fetch_issue: got %b/%h required 1/bfc00000",
                     sram_en[0], sram_addr[0]);
        end
        inst_q.push_back(32'h0000_0001);
        cyc();
        sram_rdata = 32'h0000_0001;
        #1;
        n_cmp++;
        if ({inst_ok[0], inst_rdata[0]} !== {1'b1, inst_q.pop_front()}) begin
            n_err++;
            $display("FAIL rst_then_fetch_ok: got %b/%h required 1/00000001",
                     inst_ok[0], inst_rdata[0]);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_single_fetch();
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #1;
        n_cmp++;
        if ({sram_en[0], sram_wen[0], sram_addr[0]} !== {1'b1, 4'b0000, 32'hBFC0_0000}) begin
            n_err++;
            $display("FAIL fetch_issue: got %b/%b/%h required 1/0000/bfc00000",
                     sram_en[0], sram_wen[0], sram_addr[0]);
        end
        inst_q.push_back(32'h3C08_BFAF);
        cyc();
        sram_rdata = 32'h3C08_BFAF;
        #1;
        n_cmp++;
        if ({sram_en[0], inst_ok[0], inst_rdata[0]} !== {1'b0, 1'b1, inst_q.pop_front()}) begin
            n_err++;
            $display("FAIL fetch_ok: got en=%b ok=%b %h required en=0 ok=1 3c08bfaf",
                     sram_en[0], inst_ok[0], inst_rdata[0]);
        end
        cyc();
        inst_addr  = 32'hBFC0_0004;
        sram_rdata = 32'h0;
        #1;
        n_cmp++;
        if ({sram_en[0], sram_addr[0], sram_wdata[0]} !== {1'b1, 32'hBFC0_0004, 32'h0}) begin
            n_err++;
            $display("FAIL fetch_next_issue: got %b/%h required 1/bfc00004",
                     sram_en[0], sram_addr[0]);
        end
        inst_q.push_back(32'h2408_0001);
        cyc();
        sram_rdata = 32'h2408_0001;
        #1;
        n_cmp++;
        if ({inst_ok[0], inst_rdata[0]} !== {1'b1, inst_q.pop_front()}) begin
            n_err++;
            $display("FAIL fetch_b2b_ok: got %b/%h required 1/24080001",
                     inst_ok[0], inst_rdata[0]);
        end
        idle_inputs();
        cyc();
        n_cmp++;
        if ({sram_en[0], sram_addr[0]} !== {1'b0, 32'hBFC0_0004}) begin
            n_err++;
            $display("FAIL addr_hold: got %b/%h required 0/bfc00004", sram_en[0], sram_addr[0]);
        end
    endtask

    task automatic test_priority();
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0008;
        data_req  = 1'b1;
        data_addr = 32'h8000_1004;
        #1;
        n_cmp++;
        if ({sram_en[0], sram_wen[0], sram_addr[0]} !== {1'b1, 4'b0000, 32'h8000_1004}) begin
            n_err++;
            $display("FAIL prio_data_first: got %b/%b/%h required 1/0000/80001004",
                     sram_en[0], sram_wen[0], sram_addr[0]);
        end
        data_q.push_back(32'hDEAD_BEEF);
        cyc();
        sram_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({data_ok[0], inst_ok[0], data_rdata[0]} !== {1'b1, 1'b0, data_q.pop_front()}) begin
            n_err++;
            $display("FAIL prio_data_ok: got d=%b i=%b %h required d=1 i=0 deadbeef",
                     data_ok[0], inst_ok[0], data_rdata[0]);
        end
        cyc();
        data_req = 1'b0;
        #1;
        n_cmp++;
        if ({sram_en[0], sram_addr[0]} !== {1'b1, 32'hBFC0_0008}) begin
            n_err++;
            $display("FAIL prio_fetch_second: got %b/%h required 1/bfc00008",
                     sram_en[0], sram_addr[0]);
        end
        inst_q.push_back(32'h0BAD_F00D);
        cyc();
        sram_rdata = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if ({inst_ok[0], data_ok[0], inst_rdata[0]} !== {1'b1, 1'b0, inst_q.pop_front()}) begin
            n_err++;
            $display("FAIL prio_fetch_ok: got i=%b d=%b %h required i=1 d=0 0badf00d",
                     inst_ok[0], data_ok[0], inst_rdata[0]);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_store_lanes();
        logic [1:0]  sz  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] adr [4] = '{32'h8000_0003, 32'h8000_0002, 32'h8000_0000, 32'h8000_0004};
        logic [3:0]  wen [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b1111};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_req   = 1'b1;
            data_wr    = 1'b1;
            data_size  = sz[i];
            data_addr  = adr[i];
            data_wdata = 32'h5A00_0000 + 32'(i);
            #1;
            n_cmp++;
            if ({sram_en[0], sram_wen[0], sram_addr[0], sram_wdata[0]} !==
                {1'b1, wen[i], adr[i], 32'h5A00_0000 + 32'(i)}) begin
                n_err++;
                $display("FAIL store_lane[%0d]: got %b/%b/%h/%h required 1/%b/%h/%h", i,
                         sram_en[0], sram_wen[0], sram_addr[0], sram_wdata[0],
                         wen[i], adr[i], 32'h5A00_0000 + 32'(i));
            end
            cyc();
            n_cmp++;
            if ({data_ok[0], sram_en[0], sram_wen[0]} !== {1'b1, 1'b0, 4'b0000}) begin
                n_err++;
                $display("FAIL store_ok[%0d]: got ok=%b en=%b wen=%b required 1/0/0000", i,
                         data_ok[0], sram_en[0], sram_wen[0]);
            end
            data_req = 1'b0;
            cyc();
        end
        idle_inputs();
    endtask

    task automatic test_flush_fetch();
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0100;
        #1;
        n_cmp++;
        if ({sram_en[2], sram_addr[2]} !== {1'b1, 32'hBFC0_0100}) begin
            n_err++;
            $display("FAIL flush_i_issue: got %b/%h required 1/bfc00100", sram_en[2], sram_addr[2]);
        end
        cyc();
        flush     = 1'b1;
        inst_addr = 32'hBFC0_0200;
        #1;
        n_cmp++;
        if ({inst_ok[2], sram_en[2]} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_i_wait: got ok=%b en=%b required 0/0", inst_ok[2], sram_en[2]);
        end
        cyc();
        flush = 1'b0;
        cyc();
        sram_rdata = 32'h1111_1111;
        #1;
        n_cmp++;
        if ({inst_ok[2], inst_rdata[2], sram_en[2]} !== {1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_i_suppress: got ok=%b %h en=%b required 0/00000000/0",
                     inst_ok[2], inst_rdata[2], sram_en[2]);
        end
        cyc();
        sram_rdata = 32'h0;
        #1;
        n_cmp++;
        if ({sram_en[2], sram_addr[2]} !== {1'b1, 32'hBFC0_0200}) begin
            n_err++;
            $display("FAIL flush_i_reissue: got %b/%h required 1/bfc00200", sram_en[2], sram_addr[2]);
        end
        inst_q.push_back(32'h2222_2222);
        cyc();
        cyc();
        n_cmp++;
        if (inst_ok[2] !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_early_ok: got %b required 0", inst_ok[2]);
        end
        cyc();
        sram_rdata = 32'h2222_2222;
        #1;
        n_cmp++;
        if ({inst_ok[2], inst_rdata[2]} !== {1'b1, inst_q.pop_front()}) begin
            n_err++;
            $display("FAIL lat3_ok: got %b/%h required 1/22222222", inst_ok[2], inst_rdata[2]);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_flush_data();
        do_reset();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_0010;
        data_wdata = 32'hA5A5_A5A5;
        #1;
        n_cmp++;
        if ({sram_en[1], sram_wen[1], sram_wdata[1]} !== {1'b1, 4'b1111, 32'hA5A5_A5A5}) begin
            n_err++;
            $display("FAIL flush_st_issue: got %b/%b/%h required 1/1111/a5a5a5a5",
                     sram_en[1], sram_wen[1], sram_wdata[1]);
        end
        cyc();
        flush = 1'b1;
        #1;
        n_cmp++;
        if (data_ok[1] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_st_early: data_ok got %b required 0", data_ok[1]);
        end
        cyc();
        flush = 1'b0;
        #1;
        n_cmp++;
        if (data_ok[1] !== 1'b1) begin
            n_err++;
            $display("FAIL flush_st_ok: data_ok got %b required 1", data_ok[1]);
        end
        data_req = 1'b0;
        cyc();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h8000_0014;
        #1;
        n_cmp++;
        if ({sram_en[1], sram_wen[1], sram_addr[1]} !== {1'b1, 4'b0000, 32'h8000_0014}) begin
            n_err++;
            $display("FAIL flush_ld_issue: got %b/%b/%h required 1/0000/80000014",
                     sram_en[1], sram_wen[1], sram_addr[1]);
        end
        cyc();
        flush = 1'b1;
        cyc();
        flush      = 1'b0;
        sram_rdata = 32'h7777_7777;
        #1;
        n_cmp++;
        if ({data_ok[1], data_rdata[1]} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL flush_ld_suppress: got %b/%h required 0/00000000",
                     data_ok[1], data_rdata[1]);
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_priority();
        test_store_lanes();
        test_flush_fetch();
        test_flush_data();
        n_cmp++;
        if ((inst_q.size() + data_q.size()) != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0",
                     inst_q.size() + data_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
